// File: rtl/avl_pkg.sv
// Shared types and constants for the Avalon-MM memory responder.
package avl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } avl_state_e;

    localparam logic [31:0] AVL_DEAD_WORD   = 32'hDEADBEEF;
    localparam int          AVL_WAIT_MAX    = 7;
    localparam int          AVL_RD_LAT_MAX  = 4;

endpackage

// File: rtl/avl_rd_pipe.sv
// Fixed-latency read return pipe: RD_LAT internal stages feeding a registered
// output that only reloads when a valid word arrives.
module avl_rd_pipe #(
    parameter int RD_LAT = 2,
    parameter int DATA_W = 32
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data
);

    // Index RD_LAT is the output register; 0..RD_LAT-1 are the delay stages.
    logic [RD_LAT:0]             vld_pipe;
    logic [RD_LAT:0][DATA_W-1:0] dat_pipe;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe    <= {vld_pipe[RD_LAT-1:0], in_vld};
            dat_pipe[0] <= in_data;
            for (int i = 1; i < RD_LAT; i++)
                dat_pipe[i] <= dat_pipe[i-1];
            if (vld_pipe[RD_LAT-1])
                dat_pipe[RD_LAT] <= dat_pipe[RD_LAT-1];
        end
    end

    assign out_vld  = vld_pipe[RD_LAT];
    assign out_data = dat_pipe[RD_LAT];

endmodule

// File: rtl/avl_mem_responder.sv
// Avalon-MM pipelined slave backed by an inferred byte-writable RAM, with
// programmable wait states and fixed read latency.
module avl_mem_responder
    import avl_pkg::*;
#(
    parameter int ADDR_W   = 28,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int WAIT_CYC = 1,
    parameter int RD_LAT   = 2
) (
    input  logic                iCLK,
    input  logic                iRST_n,
    input  logic [ADDR_W-1:0]   avl_addr,
    input  logic                avl_read,
    input  logic                avl_write,
    input  logic [DATA_W-1:0]   avl_wData,
    input  logic [DATA_W/8-1:0] avl_byteen,
    output logic                avl_wait,
    output logic                avl_rData_valid,
    output logic [DATA_W-1:0]   avl_rData,
    output logic                err_range,
    output logic                err_proto
);

    localparam int BE_W   = DATA_W / 8;
    localparam int AIDX_W = $clog2(DEPTH);
    localparam int WAIT_N = (WAIT_CYC > AVL_WAIT_MAX) ? AVL_WAIT_MAX : WAIT_CYC;
    localparam int RD_N   = (RD_LAT < 1) ? 1 :
                            (RD_LAT > AVL_RD_LAT_MAX) ? AVL_RD_LAT_MAX : RD_LAT;
    localparam logic [DATA_W-1:0] DEAD = DATA_W'(AVL_DEAD_WORD);

    avl_state_e  state, state_nxt;
    logic [2:0]  wait_cnt, wait_cnt_nxt;
    logic        cmd, accept;

    assign cmd = avl_read | avl_write;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                if (cmd) begin
                    if (WAIT_N == 0) begin
                        accept = 1'b1;
                    end else begin
                        state_nxt    = STALL;
                        wait_cnt_nxt = 3'd1;
                    end
                end
            end
            STALL: begin
                // A dropped command is a master abort, not an error.
                if (!cmd) begin
                    state_nxt    = IDLE;
                    wait_cnt_nxt = 3'd0;
                end else if (wait_cnt == 3'(WAIT_N)) begin
                    accept       = 1'b1;
                    state_nxt    = IDLE;
                    wait_cnt_nxt = 3'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 3'd1;
                end
            end
            default: begin
                state_nxt    = IDLE;
                wait_cnt_nxt = 3'd0;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    assign avl_wait = cmd & ~accept;

    logic              in_range, do_wr, rd_push;
    logic [AIDX_W-1:0] maddr;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] mem [DEPTH];

    assign in_range = avl_addr < ADDR_W'(DEPTH);
    assign maddr    = avl_addr[AIDX_W-1:0];
    // Read+write together resolves as a write; the read half is dropped.
    assign do_wr    = accept & avl_write & in_range;
    assign rd_push  = accept & avl_read & ~avl_write;
    // Async array read happens before the edge, so a same-cycle write yields old data.
    assign rd_word  = in_range ? mem[maddr] : DEAD;

    always_ff @(posedge iCLK) begin
        if (do_wr)
            for (int b = 0; b < BE_W; b++)
                if (avl_byteen[b])
                    mem[maddr][b*8 +: 8] <= avl_wData[b*8 +: 8];
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            err_range <= 1'b0;
            err_proto <= 1'b0;
        end else begin
            if (accept && !in_range)
                err_range <= 1'b1;
            if (accept && avl_read && avl_write)
                err_proto <= 1'b1;
        end
    end

    avl_rd_pipe #(
        .RD_LAT (RD_N),
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .iCLK     (iCLK),
        .iRST_n   (iRST_n),
        .in_vld   (rd_push),
        .in_data  (rd_word),
        .out_vld  (avl_rData_valid),
        .out_data (avl_rData)
    );

endmodule

// File: tb/tb_avl_mem_responder.sv
// Bench for avl_mem_responder: directed and random traffic against a word-array
// model, on a waited instance (A) and a zero-wait back-to-back instance (B).
module tb_avl_mem_responder;

    localparam int DEPTH  = 64;
    localparam int WAIT_A = 1;
    localparam int RD_A   = 2;
    localparam int RD_B   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [27:0] a_addr = '0, b_addr = '0;
    logic        a_rd = 0, a_wr = 0, b_rd = 0, b_wr = 0;
    logic [31:0] a_wd = '0, b_wd = '0;
    logic [3:0]  a_be = '0, b_be = '0;
    logic        a_wait, a_rv, a_erng, a_eprt;
    logic        b_wait, b_rv, b_erng, b_eprt;
    logic [31:0] a_rdat, b_rdat;

    avl_mem_responder #(.ADDR_W(28), .DATA_W(32), .DEPTH(DEPTH), .WAIT_CYC(WAIT_A), .RD_LAT(RD_A)) dut_a (
        .iCLK(clk), .iRST_n(rst_n), .avl_addr(a_addr), .avl_read(a_rd), .avl_write(a_wr),
        .avl_wData(a_wd), .avl_byteen(a_be), .avl_wait(a_wait), .avl_rData_valid(a_rv),
        .avl_rData(a_rdat), .err_range(a_erng), .err_proto(a_eprt));

    avl_mem_responder #(.ADDR_W(28), .DATA_W(32), .DEPTH(DEPTH), .WAIT_CYC(0), .RD_LAT(RD_B)) dut_b (
        .iCLK(clk), .iRST_n(rst_n), .avl_addr(b_addr), .avl_read(b_rd), .avl_write(b_wr),
        .avl_wData(b_wd), .avl_byteen(b_be), .avl_wait(b_wait), .avl_rData_valid(b_rv),
        .avl_rData(b_rdat), .err_range(b_erng), .err_proto(b_eprt));

    int npass = 0;
    int nchk  = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] b_model [4];
    bit exp_rng = 0, exp_prt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One bus command on instance A; model updated and all timing/data checked.
    task automatic a_op(input bit rd, input bit wr, input logic [27:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input string tag);
        int waits, lat;
        logic [31:0] exp;
        exp = (addr < DEPTH) ? model[addr] : 32'hDEADBEEF;
        if (wr && addr < DEPTH)
            for (int b = 0; b < 4; b++)
                if (be[b]) model[addr][b*8 +: 8] = wd[b*8 +: 8];
        if (addr >= DEPTH) exp_rng = 1;
        if (rd && wr) exp_prt = 1;
        @(posedge clk); #1;
        a_addr = addr; a_rd = rd; a_wr = wr; a_wd = wd; a_be = be;
        waits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!a_wait) break;
            waits++;
            @(posedge clk); #1;
        end
        chk({tag, "/waits"}, waits, WAIT_A);
        @(posedge clk); #1;
        a_rd = 0; a_wr = 0;
        if (rd) begin
            lat = 0;
            while (lat <= 10) begin
                @(negedge clk);
                if (a_rv) break;
                @(posedge clk);
                lat++;
            end
            if (!wr) begin
                chk({tag, "/lat"}, lat, RD_A);
                chk({tag, "/data"}, a_rdat, exp);
                @(negedge clk);
                chk({tag, "/pulse1"}, a_rv, 1'b0);
            end else begin
                chk({tag, "/no_rv"}, lat, 11);
            end
        end
        chk({tag, "/err_range"}, a_erng, exp_rng);
        chk({tag, "/err_proto"}, a_eprt, exp_prt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nrv, waits;
        logic [31:0] pre;
        // Reset values
        #12;
        chk("rst/wait", a_wait, 1'b0);
        chk("rst/rv", a_rv, 1'b0);
        chk("rst/rdata", a_rdat, 32'h0);
        chk("rst/erng", a_erng, 1'b0);
        chk("rst/eprt", a_eprt, 1'b0);
        chk("rst/b_rv", b_rv, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        for (int i = 0; i < DEPTH; i++) begin
            nchk = nchk;
            a_op(0, 1, 28'(i), $urandom, 4'hF, "fill");
        end

        a_op(0, 1, 28'd5, 32'h12345678, 4'hF, "wr5");
        a_op(1, 0, 28'd5, 32'h0, 4'h0, "rd5");
        a_op(0, 1, 28'd5, 32'hAABBCCDD, 4'b0101, "merge");
        chk("merge/model", model[5], 32'h12BB56DD);
        a_op(1, 0, 28'd5, 32'h0, 4'h0, "rd5_merged");
        a_op(1, 0, 28'(DEPTH), 32'h0, 4'h0, "oor_rd");
        a_op(0, 1, 28'(DEPTH + 3), 32'hFFFFFFFF, 4'hF, "oor_wr");
        a_op(1, 0, 28'd3, 32'h0, 4'h0, "alias3");
        a_op(1, 0, 28'(DEPTH - 1), 32'h0, 4'h0, "last");
        a_op(1, 1, 28'd7, 32'h000000A5, 4'hF, "rdwr7");
        a_op(1, 0, 28'd7, 32'h0, 4'h0, "rd7");

        for (int i = 0; i < 40; i++) begin
            int k;
            k = $urandom_range(0, 9);
            a_op(k == 0 || k > 4, k < 5, 28'($urandom_range(0, DEPTH + 3)),
                 $urandom, 4'($urandom), "rnd");
        end

        // Instance B: zero wait states, back-to-back traffic
        for (int c = 0; c < 4; c++) begin
            b_model[c] = $urandom;
            @(posedge clk); #1;
            b_addr = 28'(c); b_wr = 1; b_wd = b_model[c]; b_be = 4'hF;
            @(negedge clk);
            chk("b_wr/wait", b_wait, 1'b0);
        end
        @(posedge clk); #1 b_wr = 0;
        for (int c = 0; c < 10; c++) begin
            bit ev;
            @(posedge clk); #1;
            b_rd = (c < 4);
            b_addr = 28'(c);
            @(negedge clk);
            if (c < 4) chk("b_rd/wait", b_wait, 1'b0);
            ev = (c >= 1 + RD_B) && (c < 5 + RD_B);
            chk("b_rd/valid", b_rv, ev);
            if (ev) chk("b_rd/data", b_rdat, b_model[c - 1 - RD_B]);
        end

        // Reset one cycle after a read is accepted
        a_op(0, 1, 28'd9, 32'hCAFEF00D, 4'hF, "wr9");
        @(posedge clk); #1;
        a_addr = 28'd9; a_rd = 1;
        waits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!a_wait) break;
            waits++;
            @(posedge clk); #1;
        end
        chk("rstrd/waits", waits, WAIT_A);
        @(posedge clk); #1 a_rd = 0;
        @(posedge clk); #1 rst_n = 0;
        #1;
        chk("rstmid/rv", a_rv, 1'b0);
        chk("rstmid/rdata", a_rdat, 32'h0);
        chk("rstmid/erng", a_erng, 1'b0);
        chk("rstmid/eprt", a_eprt, 1'b0);
        chk("rstmid/wait", a_wait, 1'b0);
        exp_rng = 0; exp_prt = 0;
        @(posedge clk); #1 rst_n = 1;
        nrv = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a_rv) nrv++;
        end
        chk("rstmid/no_rv", nrv, 0);
        pre = model[9];
        chk("rstmid/model9", pre, 32'hCAFEF00D);
        a_op(1, 0, 28'd9, 32'h0, 4'h0, "retain9");

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
